// File: rtl/fp_divider.sv
// FP32 divider: radix-2 restoring mantissa division, one quotient bit per cycle.
// Round-toward-zero; fixed 28-cycle latency from the load edge to o_valid.
module fp_divider #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned ITER   = 25
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_res,
    output logic        o_valid,
    output logic        o_busy
);
    typedef enum logic [1:0] {StIdle, StPrep, StDiv, StPack} state_e;

    state_e              state_q, state_d;
    logic [31:0]         a_q, a_d, b_q, b_d;
    logic signed [9:0]   exp_q, exp_d;
    logic [MANT_W:0]     rem_q, rem_d;
    logic [MANT_W-1:0]   div_q, div_d;
    logic [MANT_W:0]     quo_q, quo_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [31:0]         res_q, res_d;
    logic                valid_q, valid_d, busy_q, busy_d;

    function automatic logic [4:0] lzc(input logic [MANT_W-1:0] v);
        logic [4:0] n;
        n = 5'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (v[i]) n = 5'(MANT_W - 1 - i);
        end
        return n;
    endfunction

    // Returns {effective exponent (10b signed), normalized 24b significand}.
    function automatic logic [MANT_W+9:0] unpack_op(input logic [31:0] x);
        logic [MANT_W-1:0] m;
        logic [4:0]        lz;
        logic signed [9:0] e;
        if (x[30:23] == 8'd0) begin
            m  = {1'b0, x[22:0]};
            lz = lzc(m);
            m  = m << lz;
            e  = 10'sd1 - $signed({5'd0, lz});
        end else begin
            m = {1'b1, x[22:0]};
            e = $signed({2'b00, x[30:23]});
        end
        return {e, m};
    endfunction

    logic [MANT_W+9:0]   op_a, op_b;
    logic signed [9:0]   ea, eb, e_adj, sh;
    logic [MANT_W-1:0]   ma, mb;
    logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign;
    logic                ge;
    logic [MANT_W:0]     diff;
    logic [22:0]         mant, sub;
    logic [31:0]         packed_res;

    always_comb begin
        op_a = unpack_op(a_q);
        op_b = unpack_op(b_q);
        ea   = op_a[MANT_W+9:MANT_W];
        ma   = op_a[MANT_W-1:0];
        eb   = op_b[MANT_W+9:MANT_W];
        mb   = op_b[MANT_W-1:0];

        a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
        b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
        a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
        b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
        a_zero = ~(|a_q[30:0]);
        b_zero = ~(|b_q[30:0]);
        sign   = a_q[31] ^ b_q[31];

        ge   = rem_q >= {1'b0, div_q};
        diff = ge ? rem_q - {1'b0, div_q} : rem_q;

        // Quotient in [1,2) lands with its leading one at bit MANT_W; otherwise one lower.
        e_adj = quo_q[MANT_W] ? exp_q : exp_q - 10'sd1;
        mant  = quo_q[MANT_W] ? quo_q[MANT_W-1:1] : quo_q[MANT_W-2:0];
        sh    = 10'sd1 - e_adj;
        sub   = (sh >= 10'sd25) ? 23'd0 : 23'({1'b1, mant} >> sh[4:0]);

        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            packed_res = 32'hFFFF_FFFF;
        end else if (a_inf || b_zero) begin
            packed_res = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            packed_res = {sign, 31'd0};
        end else if (e_adj >= 10'sd255) begin
            packed_res = {sign, 8'hFF, 23'd0};
        end else if (e_adj <= 10'sd0) begin
            packed_res = {sign, 8'd0, sub};
        end else begin
            packed_res = {sign, e_adj[7:0], mant};
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle: begin
                if (i_load) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    busy_d  = 1'b1;
                    state_d = StPrep;
                end
            end
            StPrep: begin
                exp_d   = ea - eb + 10'sd127;
                rem_d   = {1'b0, ma};
                div_d   = mb;
                quo_d   = '0;
                cnt_d   = 5'(ITER);
                state_d = StDiv;
            end
            StDiv: begin
                rem_d = diff << 1;
                quo_d = {quo_q[MANT_W-1:0], ge};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = StPack;
            end
            StPack: begin
                res_d   = packed_res;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            exp_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_res   = res_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
endmodule

// File: tb/tb_fp_divider.sv
// Testbench for fp_divider: directed vectors plus random operands against an
// exact round-toward-zero rational model of FP32 division.
module tb_fp_divider;
    logic        clk = 1'b0;
    logic        rst, load;
    logic [31:0] a, b, res;
    logic        valid, busy;
    int          n_checks = 0;
    int          n_fail   = 0;

    fp_divider dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_load (load),
        .i_a    (a),
        .i_b    (b),
        .o_res  (res),
        .o_valid(valid),
        .o_busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
        end
    endtask

    function automatic int msb24(input logic [23:0] v);
        int p;
        p = -1;
        for (int i = 0; i < 24; i++) if (v[i]) p = i;
        return p;
    endfunction

    // floor(ma * 2^sh / mb), exact.
    function automatic logic [127:0] scaled(input logic [23:0] ma, input logic [23:0] mb,
                                            input int sh);
        logic [127:0] n, d;
        if (sh >= 0) begin
            n = 128'(ma) << sh;
            d = 128'(mb);
        end else if (sh < -100) begin
            return '0;
        end else begin
            n = 128'(ma);
            d = 128'(mb) << (-sh);
        end
        return n / d;
    endfunction

    // Value of a finite operand is m * 2^(e-150); quotient truncated toward zero.
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        logic         s, xn, yn, xi, yi, xz, yz, ge;
        logic [23:0]  mx, my;
        logic [127:0] q;
        int           ex, ey, t, biased;
        s  = x[31] ^ y[31];
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        xz = (x[30:0] == 0);
        yz = (y[30:0] == 0);
        if (xn || yn || (xz && yz) || (xi && yi)) return 32'hFFFF_FFFF;
        if (xi || yz) return {s, 8'hFF, 23'd0};
        if (xz || yi) return {s, 31'd0};
        ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
        ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
        mx = {(x[30:23] != 0), x[22:0]};
        my = {(y[30:23] != 0), y[22:0]};
        t  = msb24(mx) - msb24(my);
        if (t >= 0) ge = 128'(mx) >= (128'(my) << t);
        else        ge = (128'(mx) << (-t)) >= 128'(my);
        if (!ge) t--;
        t      = t + ex - ey;
        biased = t + 127;
        if (biased >= 255) return {s, 8'hFF, 23'd0};
        if (biased >= 1) begin
            q = scaled(mx, my, ex - ey + 23 - t);
            return {s, 8'(biased), q[22:0]};
        end
        q = scaled(mx, my, ex - ey + 149);
        return {s, 8'h00, q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 9))
            0: x[30:23] = 8'h00;
            1: begin
                x[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) x[22:0] = '0;
            end
            2: x[30:0] = '0;
            3: x[30:23] = 8'($urandom_range(1, 8));
            4: x[30:23] = 8'($urandom_range(245, 254));
            default: ;
        endcase
        return x;
    endfunction

    // Entered at a negedge; returns at the negedge of the o_valid cycle.
    // Latency counts rising edges after the load edge up to the one that samples o_valid.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] want,
                         input string tag, input bit noise);
        int lat, busy_cnt;
        a    = x;
        b    = y;
        load = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (valid) begin
                lat = k + 1;
                break;
            end
            if (busy) busy_cnt++;
            if (noise) begin
                load = (k == 4) || (k == 19);
                if (load) begin
                    a = $urandom;
                    b = $urandom;
                end
            end
            @(negedge clk);
        end
        load = 1'b0;
        check_eq({tag, " latency"}, lat, 28);
        check_eq({tag, " busy_cycles"}, busy_cnt, 27);
        check_eq({tag, " busy_at_valid"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " result"}, res, want);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] want;
    } vec_t;

    vec_t vecs[$];
    int   seen_valid;

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        a    = '0;
        b    = '0;
        repeat (3) @(negedge clk);
        check_eq("reset res", res, 32'd0);
        check_eq("reset valid", {31'd0, valid}, 32'd0);
        check_eq("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "6/2", 1'b0);
        @(negedge clk);
        check_eq("6/2 pulse_width", {31'd0, valid}, 32'd0);
        check_eq("6/2 res_held", res, 32'h4040_0000);

        vecs = '{
            '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA},
            '{32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAA},
            '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF},
            '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000},
            '{32'h7F80_0000, 32'h7F80_0000, 32'hFFFF_FFFF},
            '{32'h4000_0000, 32'h7F80_0000, 32'h0000_0000},
            '{32'h0080_0000, 32'h4000_0000, 32'h0040_0000},
            '{32'h0000_0002, 32'h3F00_0000, 32'h0000_0004},
            '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000},
            '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000},
            '{32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF},
            '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000}
        };
        foreach (vecs[i]) begin
            do_op(vecs[i].x, vecs[i].y, vecs[i].want, $sformatf("dir%0d", i), 1'b0);
            @(negedge clk);
        end

        // Loads while busy must be ignored.
        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "busy_load", 1'b1);
        // Back-to-back: load presented in the o_valid cycle.
        do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, "b2b_first", 1'b0);
        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "b2b_second", 1'b0);
        @(negedge clk);

        // Reset mid-operation.
        a    = 32'h3F80_0000;
        b    = 32'h4040_0000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort busy", {31'd0, busy}, 32'd0);
        check_eq("abort res", res, 32'd0);
        check_eq("abort valid", {31'd0, valid}, 32'd0);
        seen_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) seen_valid++;
        end
        check_eq("abort no_valid", seen_valid, 0);
        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, "after_abort", 1'b0);
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] x, y;
            x = rand_fp();
            y = rand_fp();
            do_op(x, y, ref_div(x, y), $sformatf("rnd%0d a=%08h b=%08h", i, x, y), 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Sequential IEEE-754 single-precision divider, o_res = i_a / i_b; the inverse-operation companion to the FP32 multiplier.
- Uses a radix-2 restoring mantissa divider, one quotient bit per cycle.
- Handles zero, subnormal, infinity and NaN operands, and produces subnormal results.
- Rounding is round-toward-zero (truncation); overflow goes to infinity, matching the multiplier's conventions.

Parameters:
- MANT_W, 24, mantissa width including the implicit bit; fixed for FP32 and not intended to be overridden.
- ITER, 25, number of quotient bits generated: 24 plus 1 for the quotient-below-1 case.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_load  input  1  start request; sampled only in IDLE.
- i_a  input  32  dividend, FP32.
- i_b  input  32  divisor, FP32.
- o_res  output  32  quotient, FP32; holds its value until the next o_valid.
- o_valid  output  1  one-cycle pulse when o_res is updated.
- o_busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (i_rst high at clock edge): state=IDLE, o_res=0, o_valid=0, o_busy=0, all internal registers=0.
  - Reset has priority over everything and aborts an in-flight operation.
  - No o_valid is ever produced for an aborted operation.
- States: IDLE -> PREP -> DIV -> PACK -> IDLE.
- IDLE:
  - When i_load=1, capture i_a and i_b, set o_busy=1 next cycle, go to PREP.
  - i_load while not in IDLE is ignored.
- PREP (1 cycle):
  - Classify each operand as zero, subnormal, normal, infinity or NaN.
  - Subnormal operand: set effective exponent to 1, left-shift the mantissa by its leading-zero count to normalize, and subtract that count from the exponent.
  - Compute signed exponent E = Ea - Eb + 127, at least 10 bits wide.
  - Load remainder = Ma and divisor = Mb, both 24-bit with the implicit 1. Set counter = ITER.
- DIV (ITER cycles = 25), each cycle:
  - If remainder >= divisor: quotient bit = 1 and remainder -= divisor; otherwise quotient bit = 0.
  - Then remainder <<= 1 and quotient <<= 1 with the new bit inserted.
  - Decrement counter; go to PACK when it reaches 0.
  - Special-case operations still run DIV; the result is overridden in PACK.
- PACK (1 cycle): normalize and encode.
  - If quotient[24]=1: mantissa = quotient[23:1].
  - Otherwise: mantissa = quotient[22:0] and E -= 1.
  - If E >= 255: result is infinity.
  - If E <= 0: right-shift {1, mantissa} by (1 - E), truncating; shift >= 25 gives zero. Exponent field = 0.
  - Result sign = sign_a XOR sign_b.
  - Write o_res, pulse o_valid=1, o_busy=0, return to IDLE.
- Fixed latency: o_valid is high on the 28th rising edge after the edge that sampled i_load, for every operand class.
  - A new i_load is accepted in the cycle o_valid is high (state is already IDLE at that edge's output). Back-to-back throughput is 1 operation per 28 cycles.
- Special-case priority (highest first):
  1. Either operand NaN, or 0/0, or inf/inf: 0xFFFFFFFF.
  2. inf / finite: infinity with XOR sign.
  3. Nonzero finite / 0: infinity with XOR sign.
  4. 0 / nonzero, or finite / inf: zero with XOR sign.
- Infinity encoding: exponent 0xFF, mantissa 0.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), i_load one cycle: o_busy high for 27 cycles, then o_res=0x40400000 with o_valid high for exactly one cycle at edge 28.
- 0x3F800000 / 0x40400000 (1/3): o_res=0x3EAAAAAA (truncated); also 0xBF800000 / 0x40400000 gives 0xBEAAAAAA.
- Specials:
  - 0x00000000 / 0x00000000 -> 0xFFFFFFFF.
  - 0xBF800000 / 0x00000000 -> 0xFF800000.
  - 0x7F800000 / 0x7F800000 -> 0xFFFFFFFF.
  - 0x40000000 / 0x7F800000 -> 0x00000000.
  - Each with latency 28.
- Subnormal and range:
  - 0x00800000 / 0x40000000 -> 0x00400000.
  - 0x00000002 / 0x3F000000 -> 0x00000004.
  - 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow).
  - 0x00800000 / 0x7F000000 -> 0x00000000 (underflow).
- Handshake:
  - i_load re-asserted with new operands at cycles 5 and 20 of a busy operation: ignored, first result unchanged.
  - i_load asserted in the o_valid cycle: a second result arrives 28 cycles later.
- Reset mid-operation: i_rst high at cycle 10 -> next cycle o_busy=0, o_res=0; no o_valid for the aborted operation; a fresh i_load afterwards completes normally.
